// File: rtl/checker_sched_pkg.sv
// Shared encodings for the checker job scheduler: checker modes, FSM states,
// result status codes and a small one-hot helper.
package checker_sched_pkg;

  localparam logic [1:0] CHECKER_MODE_SINGLE = 2'd0;
  localparam logic [1:0] CHECKER_MODE_LOOP   = 2'd1;
  localparam logic [1:0] CHECKER_MODE_PAGE   = 2'd2;

  typedef enum logic [2:0] {
    CHECKER_SCHED_IDLE  = 3'd0,
    CHECKER_SCHED_START = 3'd1,
    CHECKER_SCHED_RUN   = 3'd2,
    CHECKER_SCHED_RESP  = 3'd3,
    CHECKER_SCHED_ACK   = 3'd4
  } sched_state_t;

  typedef enum logic [2:0] {
    CHECKER_SCHED_ST_END     = 3'd0,
    CHECKER_SCHED_ST_ERR     = 3'd1,
    CHECKER_SCHED_ST_IRQ     = 3'd2,
    CHECKER_SCHED_ST_TIMEOUT = 3'd3,
    CHECKER_SCHED_ST_ABORT   = 3'd4
  } sched_status_t;

  function automatic logic [1:0] onehot_of(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/checker_sched_if.sv
// Bundle of requester, checker and response signals around checker_sched.
// slave = the scheduler; master = requesters plus checker environment.
interface checker_sched_if #(
  parameter int TIMEOUT_W = 24
);

  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  logic [1:0]           req0_mode;
  logic [1:0]           req1_mode;
  logic [63:0]          req0_addr;
  logic [63:0]          req1_addr;
  logic                 abort;
  logic [TIMEOUT_W-1:0] cfg_timeout;
  logic [1:0]           mode_mode;
  logic [63:0]          mode_addr;
  logic                 mode_start;
  logic                 mode_end;
  logic                 mode_error;
  logic                 mode_irq;
  logic [63:0]          mode_data;
  logic                 mode_ack;
  logic                 resp_valid;
  logic                 resp_ready;
  logic                 resp_id;
  logic [2:0]           resp_status;
  logic [63:0]          resp_data;
  logic                 busy;
  logic [15:0]          stat_jobs;

  modport slave (
    input  req_valid, req0_mode, req1_mode, req0_addr, req1_addr, abort,
           cfg_timeout, mode_end, mode_error, mode_irq, mode_data, resp_ready,
    output req_ready, mode_mode, mode_addr, mode_start, mode_ack, resp_valid,
           resp_id, resp_status, resp_data, busy, stat_jobs
  );

  modport master (
    output req_valid, req0_mode, req1_mode, req0_addr, req1_addr, abort,
           cfg_timeout, mode_end, mode_error, mode_irq, mode_data, resp_ready,
    input  req_ready, mode_mode, mode_addr, mode_start, mode_ack, resp_valid,
           resp_id, resp_status, resp_data, busy, stat_jobs
  );

endinterface

// File: rtl/checker_sched_rr.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last
// time is granted. Purely combinational.
module checker_sched_rr
  import checker_sched_pkg::*;
(
  input  logic [1:0] req_valid_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o,
  output logic       grant_id_o
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a value unassigned, which would infer a latch.
    grant_o    = 2'b00;
    grant_id_o = last_grant_i;
    unique case (req_valid_i)
      2'b01:   grant_id_o = 1'b0;
      2'b10:   grant_id_o = 1'b1;
      2'b11:   grant_id_o = ~last_grant_i;
      default: grant_id_o = last_grant_i;
    endcase
    if (req_valid_i != 2'b00) grant_o = onehot_of(grant_id_o);
  end

endmodule

// File: rtl/checker_sched.sv
// Shares the checker between two requesters and sequences one job at a time
// through start, run, interrupt acknowledge and tagged completion.
module checker_sched
  import checker_sched_pkg::*;
#(
  parameter int TIMEOUT_W = 24
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  checker_sched_if.slave  bus
);

  sched_state_t         state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [1:0]           mode_mode_q, mode_mode_d;
  logic [63:0]          mode_addr_q, mode_addr_d;
  logic                 mode_start_q, mode_start_d;
  logic                 resp_id_q, resp_id_d;
  sched_status_t        resp_status_q, resp_status_d;
  logic [63:0]          resp_data_q, resp_data_d;
  logic [15:0]          stat_jobs_q, stat_jobs_d;

  logic [1:0] grant;
  logic       grant_id;
  logic       timeout_hit;
  logic       run_event;

  checker_sched_rr u_rr (
    .req_valid_i  (bus.req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .grant_id_o   (grant_id)
  );

  assign timeout_hit = (bus.cfg_timeout != '0) && (cnt_q == bus.cfg_timeout);

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    mode_mode_d   = mode_mode_q;
    mode_addr_d   = mode_addr_q;
    mode_start_d  = mode_start_q;
    resp_id_d     = resp_id_q;
    resp_status_d = resp_status_q;
    resp_data_d   = resp_data_q;
    stat_jobs_d   = stat_jobs_q;
    run_event     = 1'b0;

    unique case (state_q)
      CHECKER_SCHED_IDLE: begin
        if (grant != 2'b00) begin
          mode_mode_d  = grant_id ? bus.req1_mode : bus.req0_mode;
          mode_addr_d  = grant_id ? bus.req1_addr : bus.req0_addr;
          resp_id_d    = grant_id;
          last_grant_d = grant_id;
          state_d      = CHECKER_SCHED_START;
        end
      end

      CHECKER_SCHED_START: begin
        cnt_d = '0;
        if (bus.abort) begin
          // Job dropped before the checker ever saw mode_start.
          resp_status_d = CHECKER_SCHED_ST_ABORT;
          resp_data_d   = '0;
          state_d       = CHECKER_SCHED_RESP;
        end else begin
          mode_start_d = 1'b1;
          state_d      = CHECKER_SCHED_RUN;
        end
      end

      CHECKER_SCHED_RUN: begin
        run_event = 1'b1;
        if (bus.mode_end) begin
          resp_status_d = CHECKER_SCHED_ST_END;
          mode_start_d  = 1'b0;
        end else if (bus.mode_error) begin
          resp_status_d = CHECKER_SCHED_ST_ERR;
          mode_start_d  = 1'b0;
        end else if (bus.abort) begin
          resp_status_d = CHECKER_SCHED_ST_ABORT;
          mode_start_d  = 1'b0;
        end else if (timeout_hit) begin
          resp_status_d = CHECKER_SCHED_ST_TIMEOUT;
          mode_start_d  = 1'b0;
        end else if (bus.mode_irq) begin
          resp_status_d = CHECKER_SCHED_ST_IRQ;
        end else begin
          run_event = 1'b0;
        end

        if (run_event) begin
          resp_data_d = bus.mode_data;
          state_d     = CHECKER_SCHED_RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      CHECKER_SCHED_RESP: begin
        if (bus.resp_ready) begin
          if (resp_status_q == CHECKER_SCHED_ST_IRQ) begin
            state_d = CHECKER_SCHED_ACK;
          end else begin
            stat_jobs_d = stat_jobs_q + 16'd1;
            state_d     = CHECKER_SCHED_IDLE;
          end
        end
      end

      CHECKER_SCHED_ACK: begin
        cnt_d   = '0;
        state_d = CHECKER_SCHED_RUN;
      end

      default: state_d = CHECKER_SCHED_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= CHECKER_SCHED_IDLE;
      last_grant_q  <= 1'b1;
      cnt_q         <= '0;
      mode_mode_q   <= CHECKER_MODE_SINGLE;
      mode_addr_q   <= '0;
      mode_start_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_status_q <= CHECKER_SCHED_ST_END;
      resp_data_q   <= '0;
      stat_jobs_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of the others, independent of statement order.
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      mode_mode_q   <= mode_mode_d;
      mode_addr_q   <= mode_addr_d;
      mode_start_q  <= mode_start_d;
      resp_id_q     <= resp_id_d;
      resp_status_q <= resp_status_d;
      resp_data_q   <= resp_data_d;
      stat_jobs_q   <= stat_jobs_d;
    end
  end

  assign bus.req_ready   = (state_q == CHECKER_SCHED_IDLE) ? grant : 2'b00;
  assign bus.mode_mode   = mode_mode_q;
  assign bus.mode_addr   = mode_addr_q;
  assign bus.mode_start  = mode_start_q;
  assign bus.mode_ack    = (state_q == CHECKER_SCHED_ACK);
  assign bus.resp_valid  = (state_q == CHECKER_SCHED_RESP);
  assign bus.resp_id     = resp_id_q;
  assign bus.resp_status = resp_status_q;
  assign bus.resp_data   = resp_data_q;
  assign bus.busy        = (state_q != CHECKER_SCHED_IDLE);
  assign bus.stat_jobs   = stat_jobs_q;

endmodule

// File: tb/tb_checker_sched.sv
// Directed bench for checker_sched: plays both requesters and the checker,
// comparing every observation against hand-computed values.
module tb_checker_sched;
  import checker_sched_pkg::*;

  logic sys_clk;
  logic sys_rst_n;
  int   checks;
  int   errors;
  int   exp_jobs;

  checker_sched_if #(.TIMEOUT_W(24)) bus ();

  checker_sched #(.TIMEOUT_W(24)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_valid   = 2'b00;
    bus.req0_mode   = CHECKER_MODE_SINGLE;
    bus.req1_mode   = CHECKER_MODE_SINGLE;
    bus.req0_addr   = '0;
    bus.req1_addr   = '0;
    bus.abort       = 1'b0;
    bus.cfg_timeout = '0;
    bus.mode_end    = 1'b0;
    bus.mode_error  = 1'b0;
    bus.mode_irq    = 1'b0;
    bus.mode_data   = '0;
    bus.resp_ready  = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    sys_rst_n = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    tick();
    exp_jobs = 0;
  endtask

  // Presents a request for one cycle, returns req_ready seen in IDLE; ends in START.
  task automatic accept(input logic [1:0] v, output logic [1:0] rdy);
    bus.req_valid = v;
    #1;
    rdy = bus.req_ready;
    tick();
    bus.req_valid = 2'b00;
  endtask

  task automatic handshake();
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.req_ready, bus.mode_mode, bus.mode_addr, bus.mode_start, bus.mode_ack,
         bus.resp_valid, bus.resp_id, bus.resp_status, bus.resp_data, bus.busy,
         bus.stat_jobs} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got start=%b valid=%b busy=%b jobs=%0d addr=%h exp all zero",
               bus.mode_start, bus.resp_valid, bus.busy, bus.stat_jobs, bus.mode_addr);
    end
  endtask

  task automatic test_single();
    logic [1:0] rdy;
    int hi;
    bus.req0_mode = CHECKER_MODE_SINGLE;
    bus.req0_addr = 64'h1000;
    accept(2'b01, rdy);
    checks++;
    if (rdy !== 2'b01) begin errors++; $display("FAIL single_ready got %b exp 01", rdy); end
    checks++;
    if (bus.mode_addr !== 64'h1000 || bus.busy !== 1'b1 || bus.mode_start !== 1'b0) begin
      errors++;
      $display("FAIL single_start got addr=%h busy=%b start=%b exp 1000 1 0",
               bus.mode_addr, bus.busy, bus.mode_start);
    end
    tick();
    hi = bus.mode_start ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.mode_start) hi++;
    end
    bus.mode_end = 1'b1;
    tick();
    bus.mode_end = 1'b0;
    checks++;
    if (hi !== 6 || bus.mode_start !== 1'b0) begin
      errors++;
      $display("FAIL single_start_len got %0d cycles start=%b exp 6 cycles start=0", hi, bus.mode_start);
    end
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_status !== CHECKER_SCHED_ST_END || bus.resp_id !== 1'b0) begin
      errors++;
      $display("FAIL single_resp got valid=%b st=%0d id=%b exp 1 0 0",
               bus.resp_valid, bus.resp_status, bus.resp_id);
    end
    handshake();
    exp_jobs++;
    checks++;
    if (bus.stat_jobs !== 16'(exp_jobs) || bus.busy !== 1'b0 || bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_done got jobs=%0d busy=%b valid=%b exp %0d 0 0",
               bus.stat_jobs, bus.busy, bus.resp_valid, exp_jobs);
    end
  endtask

  task automatic test_tie();
    logic [1:0]  exp_rdy;
    logic [63:0] exp_addr;
    bit          seen;
    do_reset();
    bus.req0_addr = 64'hA0;
    bus.req1_addr = 64'hB1;
    bus.req_valid = 2'b11;
    for (int j = 0; j < 3; j++) begin
      exp_rdy  = (j == 1) ? 2'b10 : 2'b01;
      exp_addr = (j == 1) ? 64'hB1 : 64'hA0;
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
        #1;
        if (bus.req_ready != 2'b00) begin seen = 1'b1; break; end
        tick();
      end
      checks++;
      if (!seen || bus.req_ready !== exp_rdy) begin
        errors++;
        $display("FAIL tie_grant%0d got %b exp %b", j, bus.req_ready, exp_rdy);
      end
      tick();
      tick();
      bus.mode_end = 1'b1;
      tick();
      bus.mode_end = 1'b0;
      checks++;
      if (bus.resp_id !== exp_rdy[1] || bus.mode_addr !== exp_addr || bus.resp_valid !== 1'b1) begin
        errors++;
        $display("FAIL tie_resp%0d got id=%b addr=%h valid=%b exp %b %h 1",
                 j, bus.resp_id, bus.mode_addr, bus.resp_valid, exp_rdy[1], exp_addr);
      end
      handshake();
      exp_jobs++;
    end
    bus.req_valid = 2'b00;
    checks++;
    if (bus.stat_jobs !== 16'(exp_jobs)) begin
      errors++;
      $display("FAIL tie_jobs got %0d exp %0d", bus.stat_jobs, exp_jobs);
    end
  endtask

  task automatic test_irq();
    logic [1:0] rdy;
    bus.req1_mode = CHECKER_MODE_PAGE;
    bus.req1_addr = 64'h2000;
    accept(2'b10, rdy);
    tick();
    bus.mode_irq  = 1'b1;
    bus.mode_data = 64'hDEAD;
    tick();
    bus.mode_irq  = 1'b0;
    bus.mode_data = '0;
    checks++;
    if (rdy !== 2'b10 || bus.mode_mode !== CHECKER_MODE_PAGE) begin
      errors++;
      $display("FAIL irq_grant got rdy=%b mode=%0d exp 10 %0d", rdy, bus.mode_mode, CHECKER_MODE_PAGE);
    end
    checks++;
    if (bus.resp_status !== CHECKER_SCHED_ST_IRQ || bus.resp_data !== 64'hDEAD ||
        bus.mode_start !== 1'b1 || bus.resp_id !== 1'b1 || bus.mode_ack !== 1'b0) begin
      errors++;
      $display("FAIL irq_resp got st=%0d data=%h start=%b id=%b ack=%b exp 2 dead 1 1 0",
               bus.resp_status, bus.resp_data, bus.mode_start, bus.resp_id, bus.mode_ack);
    end
    handshake();
    checks++;
    if (bus.mode_ack !== 1'b1 || bus.resp_valid !== 1'b0 || bus.stat_jobs !== 16'(exp_jobs)) begin
      errors++;
      $display("FAIL irq_ack got ack=%b valid=%b jobs=%0d exp 1 0 %0d",
               bus.mode_ack, bus.resp_valid, bus.stat_jobs, exp_jobs);
    end
    tick();
    checks++;
    if (bus.mode_ack !== 1'b0 || bus.mode_start !== 1'b1) begin
      errors++;
      $display("FAIL irq_ack_len got ack=%b start=%b exp 0 1", bus.mode_ack, bus.mode_start);
    end
    bus.mode_end  = 1'b1;
    bus.mode_data = 64'h55;
    tick();
    bus.mode_end  = 1'b0;
    bus.mode_data = '0;
    checks++;
    if (bus.resp_status !== CHECKER_SCHED_ST_END || bus.resp_data !== 64'h55) begin
      errors++;
      $display("FAIL irq_end got st=%0d data=%h exp 0 55", bus.resp_status, bus.resp_data);
    end
    handshake();
    exp_jobs++;
    checks++;
    if (bus.stat_jobs !== 16'(exp_jobs)) begin
      errors++;
      $display("FAIL irq_jobs got %0d exp %0d", bus.stat_jobs, exp_jobs);
    end
  endtask

  task automatic test_timeout();
    logic [1:0] rdy;
    int  hi;
    bit  got;
    bus.cfg_timeout = 24'd10;
    accept(2'b01, rdy);
    tick();
    hi  = 0;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.resp_valid) begin got = 1'b1; break; end
      if (bus.mode_start) hi++;
      tick();
    end
    checks++;
    if (!got || hi !== 11 || bus.resp_status !== CHECKER_SCHED_ST_TIMEOUT || bus.mode_start !== 1'b0) begin
      errors++;
      $display("FAIL timeout_10 got resp=%b run=%0d st=%0d start=%b exp 1 11 3 0",
               got, hi, bus.resp_status, bus.mode_start);
    end
    handshake();
    exp_jobs++;

    bus.cfg_timeout = '0;
    accept(2'b01, rdy);
    tick();
    got = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (bus.resp_valid) got = 1'b1;
      tick();
    end
    checks++;
    if (got || bus.mode_start !== 1'b1) begin
      errors++;
      $display("FAIL timeout_off got resp=%b start=%b exp 0 1", got, bus.mode_start);
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks++;
    if (bus.resp_status !== CHECKER_SCHED_ST_ABORT || bus.mode_start !== 1'b0 || bus.resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL run_abort got st=%0d start=%b valid=%b exp 4 0 1",
               bus.resp_status, bus.mode_start, bus.resp_valid);
    end
    handshake();
    exp_jobs++;
  endtask

  task automatic test_simultaneous();
    logic [1:0] rdy;
    bit saw_ack;
    accept(2'b10, rdy);
    tick();
    bus.mode_end   = 1'b1;
    bus.mode_error = 1'b1;
    bus.mode_irq   = 1'b1;
    bus.abort      = 1'b1;
    bus.mode_data  = 64'h77;
    tick();
    clear_inputs();
    checks++;
    if (bus.resp_status !== CHECKER_SCHED_ST_END || bus.resp_data !== 64'h77) begin
      errors++;
      $display("FAIL simul_status got st=%0d data=%h exp 0 77", bus.resp_status, bus.resp_data);
    end
    handshake();
    exp_jobs++;
    saw_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.mode_ack || bus.busy) saw_ack = 1'b1;
      tick();
    end
    checks++;
    if (saw_ack || bus.stat_jobs !== 16'(exp_jobs)) begin
      errors++;
      $display("FAIL simul_no_ack got ack_or_busy=%b jobs=%0d exp 0 %0d", saw_ack, bus.stat_jobs, exp_jobs);
    end
  endtask

  task automatic test_abort_start();
    logic [1:0] rdy;
    accept(2'b01, rdy);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_status !== CHECKER_SCHED_ST_ABORT || bus.mode_start !== 1'b0) begin
      errors++;
      $display("FAIL start_abort got valid=%b st=%0d start=%b exp 1 4 0",
               bus.resp_valid, bus.resp_status, bus.mode_start);
    end
    handshake();
    exp_jobs++;
    checks++;
    if (bus.stat_jobs !== 16'(exp_jobs) || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL start_abort_done got jobs=%0d busy=%b exp %0d 0", bus.stat_jobs, bus.busy, exp_jobs);
    end
  endtask

  task automatic test_reset_mid_resp();
    logic [1:0] rdy;
    bus.req0_addr = 64'h3000;
    accept(2'b01, rdy);
    tick();
    bus.mode_irq  = 1'b1;
    bus.mode_data = 64'hBEEF;
    tick();
    bus.mode_irq  = 1'b0;
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.mode_start !== 1'b1) begin
      errors++;
      $display("FAIL rst_setup got valid=%b start=%b exp 1 1", bus.resp_valid, bus.mode_start);
    end
    bus.req_valid = 2'b00;
    #1;
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready, bus.mode_mode, bus.mode_addr, bus.mode_start, bus.mode_ack,
         bus.resp_valid, bus.resp_id, bus.resp_status, bus.resp_data, bus.busy,
         bus.stat_jobs} !== '0) begin
      errors++;
      $display("FAIL rst_async got start=%b valid=%b busy=%b jobs=%0d data=%h exp all zero",
               bus.mode_start, bus.resp_valid, bus.busy, bus.stat_jobs, bus.resp_data);
    end
    clear_inputs();
    tick();
    sys_rst_n = 1'b1;
    tick();
    exp_jobs = 0;
    bus.req_valid = 2'b11;
    #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++;
      $display("FAIL rst_regrant got %b exp 01", bus.req_ready);
    end
    bus.req_valid = 2'b00;
    tick();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    exp_jobs  = 0;
    sys_rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single();
    test_tie();
    test_irq();
    test_timeout();
    test_simultaneous();
    test_abort_start();
    test_reset_mid_resp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
